axi4_burst_master: RTL and testbench

// Parametrised AXI4 full master. Executes one command per cmd handshake:
// - Write: INCR burst write of cmd_len+1 beats (AW and W concurrent, then B).
// - Read: INCR burst read (AR then R), each beat checked against an expected pattern.

---
 rtl/axi4_burst_master.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: AXI4 full master that runs one INCR burst per command.
// A write drives AW and W concurrently and then waits for B. A read drives AR
// and then checks every R beat against the pattern seed+beat.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   cmd_*                 command handshake and payload (write/addr/len/id/seed)
//   done, status          1-cycle completion pulse, {reject,timeout,mismatch,resp_err}
//   mism_cnt              saturating count of mismatched read beats
//   M_AXI_AW*/W*/B*       write address, data and response channels
//   M_AXI_AR*/R*          read address and data channels
module axi4_burst_master #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [DATA_W-1:0]   cmd_seed,
    output logic                done,
    output logic [3:0]          status,
    output logic [15:0]         mism_cnt,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [ID_W-1:0]     M_AXI_AWID,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic [ID_W-1:0]     M_AXI_BID,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [ID_W-1:0]     M_AXI_ARID,
    output logic [7:0]          M_AXI_ARLEN,
    output logic [2:0]          M_AXI_ARSIZE,
    output logic [1:0]          M_AXI_ARBURST,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic [ID_W-1:0]     M_AXI_RID,
    input  logic                M_AXI_RLAST,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned LSB     = $clog2(BYTES);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  AX_SIZE = 3'(LSB);

    typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD_A, RD_D, DONE} state_t;

    state_t              state_q, state_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                w_last_q, w_last_d;
    logic                b_ready_q, b_ready_d;
    logic                ar_valid_q, ar_valid_d;
    logic                r_ready_q, r_ready_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                done_q, done_d;
    logic [3:0]          status_q, status_d;
    logic [15:0]         mism_q, mism_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          beat_q, beat_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                aw_fin, w_fin, last_exp;

    // Handshakes and command legality
    logic cmd_hs_c, aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, any_hs_c;
    logic [13:0] span_c;
    logic reject_c;

    assign cmd_hs_c = cmd_valid && cmd_ready_q;
    assign aw_hs_c  = aw_valid_q && M_AXI_AWREADY;
    assign w_hs_c   = w_valid_q && M_AXI_WREADY;
    assign b_hs_c   = b_ready_q && M_AXI_BVALID;
    assign ar_hs_c  = ar_valid_q && M_AXI_ARREADY;
    assign r_hs_c   = r_ready_q && M_AXI_RVALID;
    assign any_hs_c = aw_hs_c || w_hs_c || b_hs_c || ar_hs_c || r_hs_c;

    // End address of the burst within its 4KB page; beyond 4096 means a crossing
    assign span_c   = 14'(cmd_addr[11:0]) + (14'(cmd_len) + 14'd1) * 14'(BYTES);
    assign reject_c = (32'(cmd_len) >= MAX_LEN) ||
                      (cmd_addr[LSB-1:0] != '0) ||
                      (span_c > 14'd4096);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        w_last_d    = w_last_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        cmd_ready_d = cmd_ready_q;
        status_d    = status_q;
        mism_d      = mism_q;
        addr_d      = addr_q;
        len_d       = len_q;
        id_d        = id_q;
        data_d      = data_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_fin      = aw_done_q;
        w_fin       = w_done_q;
        last_exp    = (beat_q == len_q);

        // Idle-time counter: restarts whenever any channel makes progress
        if (state_q == IDLE || state_q == DONE || any_hs_c) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_hs_c) begin
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    id_d        = cmd_id;
                    data_d      = cmd_seed;
                    beat_d      = 8'd0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    status_d    = 4'b0000;
                    mism_d      = 16'd0;
                    cmd_ready_d = 1'b0;
                    if (reject_c) begin
                        status_d = 4'b1000;
                        state_d  = DONE;
                    end else if (cmd_write) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        w_last_d   = (cmd_len == 8'd0);
                        state_d    = WR;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_A;
                    end
                end
            end
            WR: begin
                if (aw_hs_c) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                    aw_fin     = 1'b1;
                end
                if (w_hs_c) begin
                    data_d = data_q + DATA_W'(1);
                    if (w_last_q) begin
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                        w_done_d  = 1'b1;
                        w_fin     = 1'b1;
                    end else begin
                        beat_d   = beat_q + 8'd1;
                        w_last_d = ((beat_q + 8'd1) == len_q);
                    end
                end
                if (aw_fin && w_fin) begin
                    b_ready_d = 1'b1;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (b_hs_c) begin
                    b_ready_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00 || M_AXI_BID != id_q) begin
                        status_d[0] = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            RD_A: begin
                if (ar_hs_c) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_D;
                end
            end
            RD_D: begin
                if (r_hs_c) begin
                    data_d = data_q + DATA_W'(1);
                    beat_d = beat_q + 8'd1;
                    if (M_AXI_RDATA != data_q || M_AXI_RID != id_q ||
                        M_AXI_RLAST != last_exp) begin
                        status_d[1] = 1'b1;
                        if (mism_q != 16'hFFFF) begin
                            mism_d = mism_q + 16'd1;
                        end
                    end
                    if (M_AXI_RRESP != 2'b00) begin
                        status_d[0] = 1'b1;
                    end
                    // Stop on whichever comes first: slave's RLAST or our own count
                    if (M_AXI_RLAST || last_exp) begin
                        r_ready_d = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort: drop every VALID/READY without completing the transfer
        if (state_q != IDLE && state_q != DONE && !any_hs_c &&
            tmo_q == TMO_W'(TIMEOUT - 1)) begin
            aw_valid_d  = 1'b0;
            w_valid_d   = 1'b0;
            w_last_d    = 1'b0;
            b_ready_d   = 1'b0;
            ar_valid_d  = 1'b0;
            r_ready_d   = 1'b0;
            status_d[2] = 1'b1;
            state_d     = DONE;
        end

        // done is high for exactly the single cycle spent in DONE
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            status_q    <= 4'b0000;
            mism_q      <= 16'd0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            id_q        <= '0;
            data_q      <= '0;
            beat_q      <= 8'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            w_last_q    <= w_last_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            status_q    <= status_d;
            mism_q      <= mism_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            id_q        <= id_d;
            data_q      <= data_d;
            beat_q      <= beat_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign done          = done_q;
    assign status        = status_q;
    assign mism_cnt      = mism_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWID    = id_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = AX_SIZE;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = aw_valid_q;

    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_last_q;
    assign M_AXI_WVALID  = w_valid_q;

    assign M_AXI_BREADY  = b_ready_q;

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARID    = id_q;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = AX_SIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = ar_valid_q;

    assign M_AXI_RREADY  = r_ready_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: directed bench for axi4_burst_master with a small
// memory-backed AXI slave whose stalls, responses and data corruption are
// controlled from the main sequence.
module tb_axi4_burst_master;

    localparam int unsigned TO = 64;

    logic        ACLK, ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_seed;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        done;
    logic [3:0]  status;
    logic [15:0] mism_cnt;

    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [3:0]  M_AXI_AWID, M_AXI_WSTRB, M_AXI_BID, M_AXI_ARID, M_AXI_RID;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE;
    logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    axi4_burst_master #(
        .DATA_W(32), .ADDR_W(32), .ID_W(4), .MAX_LEN(16), .TIMEOUT(TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_seed(cmd_seed),
        .done(done), .status(status), .mism_cnt(mism_cnt),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BID(M_AXI_BID), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RID(M_AXI_RID),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    // Slave knobs, written by the main sequence
    bit       aw_hold  = 1'b0;
    bit       w_stall  = 1'b0;
    bit       r_enable = 1'b1;
    bit [1:0] bresp_k  = 2'b00;
    int       corrupt_beat = -1;

    // Slave state and logs, written only by the posedge process
    int          cyc, w_beats, w_commit, r_beat, r_total, vcyc, stab_viol;
    bit          aw_seen, wl_seen, b_pend, r_act;
    logic [31:0] aw_addr_s, ar_addr_s;
    logic [7:0]  aw_len_s, ar_len_s;
    logic [3:0]  aw_id_s, ar_id_s, b_id_s;
    logic [31:0] wlog [0:255];
    bit          wlast_log [0:255];
    bit   [31:0] mem [0:1023];
    bit          p_aw_st, p_w_st, p_ar_st, p_wlast;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [7:0]  p_awlen, p_arlen;

    // Slave: observe handshakes, log W beats, commit to memory, track stalls
    always @(posedge ACLK) begin
        cyc = cyc + 1;
        if (ARESET) begin
            aw_seen = 1'b0; wl_seen = 1'b0; b_pend = 1'b0; r_act = 1'b0;
            p_aw_st = 1'b0; p_w_st = 1'b0; p_ar_st = 1'b0;
            w_commit = w_beats;
        end else begin
            if (p_aw_st && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr || M_AXI_AWLEN != p_awlen))
                stab_viol = stab_viol + 1;
            if (p_w_st && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata || M_AXI_WLAST != p_wlast))
                stab_viol = stab_viol + 1;
            if (p_ar_st && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr || M_AXI_ARLEN != p_arlen))
                stab_viol = stab_viol + 1;
            p_aw_st = M_AXI_AWVALID && !M_AXI_AWREADY;
            p_w_st  = M_AXI_WVALID && !M_AXI_WREADY;
            p_ar_st = M_AXI_ARVALID && !M_AXI_ARREADY;
            p_awaddr = M_AXI_AWADDR; p_awlen = M_AXI_AWLEN;
            p_wdata  = M_AXI_WDATA;  p_wlast = M_AXI_WLAST;
            p_araddr = M_AXI_ARADDR; p_arlen = M_AXI_ARLEN;
            if (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID) vcyc = vcyc + 1;

            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_seen = 1'b1; aw_addr_s = M_AXI_AWADDR;
                aw_len_s = M_AXI_AWLEN; aw_id_s = M_AXI_AWID;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                wlog[w_beats % 256] = M_AXI_WDATA;
                wlast_log[w_beats % 256] = M_AXI_WLAST;
                w_beats = w_beats + 1;
                if (M_AXI_WLAST) wl_seen = 1'b1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 1'b0;
            if (!b_pend && aw_seen && wl_seen) begin
                for (int k = 0; k <= int'(aw_len_s); k++)
                    mem[10'(aw_addr_s[11:2] + 10'(k))] = wlog[(w_commit + k) % 256];
                w_commit = w_commit + int'(aw_len_s) + 1;
                b_pend = 1'b1; b_id_s = aw_id_s;
                aw_seen = 1'b0; wl_seen = 1'b0;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                r_act = 1'b1; r_beat = 0; ar_addr_s = M_AXI_ARADDR;
                ar_len_s = M_AXI_ARLEN; ar_id_s = M_AXI_ARID;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                r_beat = r_beat + 1; r_total = r_total + 1;
                if (M_AXI_RLAST) r_act = 1'b0;
            end
        end
    end

    // Slave: drive responses away from the sampling edge
    logic [31:0] rd;
    always @(negedge ACLK) begin
        M_AXI_AWREADY = !aw_hold;
        M_AXI_WREADY  = !w_stall || cyc[0];
        M_AXI_BVALID  = b_pend;
        M_AXI_BID     = b_id_s;
        M_AXI_BRESP   = bresp_k;
        M_AXI_ARREADY = 1'b1;
        M_AXI_RVALID  = r_act && r_enable;
        rd = mem[10'(ar_addr_s[11:2] + 10'(r_beat))];
        if (r_beat == corrupt_beat) rd = rd ^ 32'h1;
        M_AXI_RDATA   = rd;
        M_AXI_RLAST   = (r_beat == int'(ar_len_s));
        M_AXI_RID     = ar_id_s;
        M_AXI_RRESP   = 2'b00;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [7:0] l,
                            input logic [3:0] id, input logic [31:0] seed);
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
        cmd_len = l; cmd_id = id; cmd_seed = seed;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        check(tag, 64'(done), 64'h1);
    endtask

    int n, b0, r0, v0, sv0;
    logic [31:0] ra [3];
    logic [7:0]  rl [3];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_id = '0; cmd_seed = '0;
        repeat (3) @(negedge ACLK);

        // Reset values
        check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("rst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY,
                                 M_AXI_RREADY, M_AXI_WLAST, done}), 64'h0);
        check("rst_status", 64'(status), 64'h0);
        check("rst_mism", 64'(mism_cnt), 64'h0);
        check("rst_awaddr", 64'(M_AXI_AWADDR), 64'h0);
        check("rst_size", 64'({M_AXI_AWSIZE, M_AXI_ARSIZE}), 64'h12);
        check("rst_burst", 64'({M_AXI_AWBURST, M_AXI_ARBURST}), 64'h5);
        ARESET = 1'b0;

        // 4-beat write, always-ready slave
        b0 = w_beats; sv0 = stab_viol;
        send_cmd(1'b1, 32'h4, 8'd3, 4'h5, 32'h1000_0000);
        check("wr_strb", 64'(M_AXI_WSTRB), 64'hF);
        wait_done("wr_done", n);
        check("wr_status", 64'(status), 64'h0);
        check("wr_beats", 64'(w_beats - b0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("wr_data", 64'(wlog[(b0 + k) % 256]), 64'(32'h1000_0000 + 32'(k)));
            check("wr_last", 64'(wlast_log[(b0 + k) % 256]), 64'(k == 3));
        end
        check("wr_aw", 64'({aw_addr_s, aw_len_s, aw_id_s}), 64'h0000_0004_035);
        @(negedge ACLK);
        check("wr_done_pulse", 64'(done), 64'h0);
        check("wr_idle_ready", 64'(cmd_ready), 64'h1);

        // Read back the same burst
        r0 = r_total;
        send_cmd(1'b0, 32'h4, 8'd3, 4'h5, 32'h1000_0000);
        wait_done("rd_done", n);
        check("rd_status", 64'(status), 64'h0);
        check("rd_mism", 64'(mism_cnt), 64'h0);
        check("rd_beats", 64'(r_total - r0), 64'd4);

        // Read back with beat 2 corrupted
        corrupt_beat = 2; r0 = r_total;
        send_cmd(1'b0, 32'h4, 8'd3, 4'h5, 32'h1000_0000);
        wait_done("rdc_done", n);
        check("rdc_status", 64'(status), 64'h2);
        check("rdc_mism", 64'(mism_cnt), 64'h1);
        check("rdc_beats", 64'(r_total - r0), 64'd4);
        corrupt_beat = -1;
        repeat (3) @(negedge ACLK);
        check("rdc_status_hold", 64'({status, mism_cnt}), 64'h2_0001);

        // AWREADY held until 5 cycles after all W beats, with W stalls
        aw_hold = 1'b1; w_stall = 1'b1; b0 = w_beats; sv0 = stab_viol;
        send_cmd(1'b1, 32'h40, 8'd5, 4'h3, 32'h0000_00A0);
        for (int i = 0; i < 200 && (w_beats - b0) < 6; i++) @(negedge ACLK);
        check("stl_w_all", 64'(w_beats - b0), 64'd6);
        repeat (5) @(negedge ACLK);
        check("stl_aw_held", 64'(M_AXI_AWVALID), 64'h1);
        aw_hold = 1'b0;
        wait_done("stl_done", n);
        w_stall = 1'b0;
        check("stl_status", 64'(status), 64'h0);
        for (int k = 0; k < 6; k++)
            check("stl_data", 64'(wlog[(b0 + k) % 256]), 64'(32'hA0 + 32'(k)));
        check("stl_stable", 64'(stab_viol - sv0), 64'h0);

        // Single-beat write with SLVERR, then single-beat read
        bresp_k = 2'b10; b0 = w_beats;
        send_cmd(1'b1, 32'h100, 8'd0, 4'h7, 32'h55);
        wait_done("l0w_done", n);
        bresp_k = 2'b00;
        check("l0w_status", 64'(status), 64'h1);
        check("l0w_beats", 64'(w_beats - b0), 64'd1);
        check("l0w_beat", 64'({wlog[b0 % 256], 4'(wlast_log[b0 % 256])}), 64'h55_1);
        r0 = r_total;
        send_cmd(1'b0, 32'h100, 8'd0, 4'h7, 32'h55);
        wait_done("l0r_done", n);
        check("l0r_status", 64'({status, mism_cnt}), 64'h0);
        check("l0r_beats", 64'(r_total - r0), 64'd1);

        // Rejected commands: 4KB crossing, misaligned, too long
        ra[0] = 32'hFF8; rl[0] = 8'd3;
        ra[1] = 32'h2;   rl[1] = 8'd0;
        ra[2] = 32'h0;   rl[2] = 8'd16;
        for (int t = 0; t < 3; t++) begin
            v0 = vcyc;
            send_cmd(t != 2, ra[t], rl[t], 4'h1, 32'h0);
            wait_done("rej_done", n);
            check("rej_status", 64'(status), 64'h8);
            check("rej_no_bus", 64'(vcyc - v0), 64'h0);
        end

        // Largest legal bursts: ending exactly on 4KB, and MAX_LEN beats
        b0 = w_beats;
        send_cmd(1'b1, 32'hFF0, 8'd3, 4'h2, 32'h7000);
        wait_done("edge_done", n);
        check("edge_status", 64'(status), 64'h0);
        check("edge_beats", 64'(w_beats - b0), 64'd4);
        b0 = w_beats;
        send_cmd(1'b1, 32'h0, 8'd15, 4'h4, 32'hFFFF_FFF8);
        wait_done("max_done", n);
        check("max_status", 64'(status), 64'h0);
        check("max_beats", 64'(w_beats - b0), 64'd16);
        check("max_last", 64'({wlog[(b0 + 15) % 256], 4'(wlast_log[(b0 + 15) % 256]),
                               4'(wlast_log[(b0 + 14) % 256])}), 64'h0000_0007_10);

        // Slave never returns read data
        r_enable = 1'b0;
        send_cmd(1'b0, 32'h0, 8'd1, 4'h2, 32'h0);
        wait_done("tmo_done", n);
        check("tmo_status", 64'(status), 64'h4);
        check("tmo_time", 64'(n >= int'(TO) - 1 && n <= int'(TO) + 3), 64'h1);
        check("tmo_dropped", 64'({M_AXI_ARVALID, M_AXI_RREADY}), 64'h0);

        // Reset in the middle of a write burst
        aw_hold = 1'b1; w_stall = 1'b1;
        send_cmd(1'b1, 32'h300, 8'd7, 4'h1, 32'h900);
        repeat (3) @(negedge ACLK);
        check("mrst_busy", 64'(M_AXI_WVALID), 64'h1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mrst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY,
                                  M_AXI_RREADY, M_AXI_WLAST, done}), 64'h0);
        check("mrst_idle", 64'({cmd_ready, status}), 64'h10);
        ARESET = 1'b0; aw_hold = 1'b0; w_stall = 1'b0; r_enable = 1'b1;

        // Normal operation after the reset
        b0 = w_beats;
        send_cmd(1'b1, 32'h200, 8'd1, 4'h9, 32'hCAFE_0000);
        wait_done("rec_done", n);
        check("rec_status", 64'(status), 64'h0);
        check("rec_beats", 64'(w_beats - b0), 64'd2);
        check("rec_data", 64'({wlog[b0 % 256], wlog[(b0 + 1) % 256]}), 64'hCAFE_0000_CAFE_0001);
        send_cmd(1'b0, 32'h200, 8'd1, 4'h9, 32'hCAFE_0000);
        wait_done("recr_done", n);
        check("recr_status", 64'({status, mism_cnt}), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
